// File: rtl/wb_extmem_responder.sv
// wb_extmem_responder: Wishbone classic responder splitting 16-bit accesses into two 8-bit external memory phases
module wb_extmem_responder #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] ADDR_LIMIT  = 16'h8000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [15:0] wb_adr,
    input  logic [15:0] wb_i_dat,
    input  logic [1:0]  wb_sel,
    output logic [15:0] wb_o_dat,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [16:0] ext_adr,
    output logic [7:0]  ext_dat_o,
    input  logic [7:0]  ext_dat_i,
    output logic        ext_oe,
    output logic        ext_we
);
    typedef enum logic [2:0] {IDLE, LO, HI, ACK, ERR} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] adr, adr_n, dat, dat_n, rd_n;
    logic        we, we_n;
    logic [1:0]  sel, sel_n;
    logic        cur_hi, nxt_hi, phase_n, lane_n;
    logic [7:0]  byte_in;
    logic [16:0] ext_adr_n;
    logic [7:0]  ext_dat_o_n;
    // next state, request latch and read capture; outputs are derived from the next state so they register in step
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        adr_n   = adr;
        dat_n   = dat;
        we_n    = we;
        sel_n   = sel;
        rd_n    = wb_o_dat;
        cur_hi  = state == HI;
        byte_in = (sel[cur_hi] && !we) ? ext_dat_i : 8'h00;
        case (state)
            IDLE: if (wb_cyc && wb_stb) begin
                if (wb_adr >= ADDR_LIMIT) state_n = ERR;
                else begin
                    adr_n   = wb_adr;
                    dat_n   = wb_i_dat;
                    we_n    = wb_we;
                    sel_n   = wb_sel;
                    cnt_n   = 4'(WAIT_CYCLES);
                    rd_n    = 16'h0000;
                    state_n = LO;
                end
            end
            LO, HI: begin
                if (!wb_cyc) state_n = IDLE;
                else if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                else begin
                    cnt_n   = 4'(WAIT_CYCLES);
                    state_n = cur_hi ? ACK : HI;
                    if (cur_hi) rd_n[15:8] = byte_in;
                    else rd_n[7:0] = byte_in;
                end
            end
            default: state_n = IDLE;
        endcase
        nxt_hi      = state_n == HI;
        phase_n     = state_n == LO || nxt_hi;
        lane_n      = phase_n && sel_n[nxt_hi];
        ext_adr_n   = phase_n ? {adr_n, nxt_hi} : 17'h0;
        ext_dat_o_n = phase_n ? (nxt_hi ? dat_n[15:8] : dat_n[7:0]) : 8'h00;
    end
    // state and registered outputs, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            adr       <= 16'h0;
            dat       <= 16'h0;
            we        <= 1'b0;
            sel       <= 2'b00;
            wb_o_dat  <= 16'h0;
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            ext_adr   <= 17'h0;
            ext_dat_o <= 8'h00;
            ext_oe    <= 1'b0;
            ext_we    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            adr       <= adr_n;
            dat       <= dat_n;
            we        <= we_n;
            sel       <= sel_n;
            wb_o_dat  <= rd_n;
            wb_ack    <= state_n == ACK;
            wb_err    <= state_n == ERR;
            ext_adr   <= ext_adr_n;
            ext_dat_o <= ext_dat_o_n;
            ext_oe    <= lane_n && !we_n;
            ext_we    <= lane_n && we_n;
        end
    end
endmodule

// File: tb/tb_wb_extmem_responder.sv
// tb_wb_extmem_responder: randomized scoreboard bench over three wait-state configurations
module tb_wb_extmem_responder;
    logic clk = 0;
    always #5 clk = ~clk;
    int cycle = 0;
    // free-running cycle index; a value seen at a negedge names that cycle
    always @(posedge clk) cycle <= cycle + 1;
    int checks = 0, errors = 0;
    bit done [3];
    typedef struct {bit err; logic [15:0] dat; int at; int nstb;} exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g;
        logic        rst_n = 0, cyc = 0, stb = 0, we = 0;
        logic [15:0] adr = 0, idat = 0;
        logic [1:0]  sel = 0;
        logic [15:0] odat;
        logic        ack, err, oe, ewe;
        logic [16:0] eadr;
        logic [7:0]  edo, edi;
        logic [7:0]  mem [0:1023];
        logic [7:0]  ref_mem [0:1023];
        exp_t        q[$];
        logic [15:0] cur_adr = 0, cur_dat = 0;
        logic        cur_we = 0;
        logic [1:0]  cur_sel = 0;
        int          nstb = 0, last_ack = 0;

        wb_extmem_responder #(.WAIT_CYCLES(W)) dut (
            .i_clk(clk), .i_rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
            .wb_adr(adr), .wb_i_dat(idat), .wb_sel(sel), .wb_o_dat(odat),
            .wb_ack(ack), .wb_err(err), .ext_adr(eadr), .ext_dat_o(edo),
            .ext_dat_i(edi), .ext_oe(oe), .ext_we(ewe)
        );

        // asynchronous byte memory; a recognisable junk value when not output-enabled
        assign edi = oe ? mem[eadr[9:0]] : 8'hEE;
        always @(posedge clk) if (ewe) mem[eadr[9:0]] <= edo;

        // monitor: protocol checks every cycle, scoreboard pop on each response
        always @(negedge clk) begin
            exp_t e;
            if (rst_n) begin
                if (oe || ewe) begin
                    nstb++;
                    chk("oe_we_excl", 32'(oe & ewe), 0);
                    chk("ext_adr_word", 32'(eadr[16:1]), 32'(cur_adr));
                    chk("ext_dir", 32'(ewe), 32'(cur_we));
                    chk("lane_enabled", 32'(cur_sel[eadr[0]]), 1);
                    if (ewe) chk("ext_dat_o", 32'(edo), 32'(eadr[0] ? cur_dat[15:8] : cur_dat[7:0]));
                end
                if (ack || err) begin
                    chk("ack_err_excl", 32'(ack & err), 0);
                    if (q.size() == 0) chk("unexpected_resp", 32'(q.size()), 1);
                    else begin
                        e = q.pop_front();
                        chk("resp_kind_err", 32'(err), 32'(e.err));
                        chk("resp_cycle", 32'(cycle), 32'(e.at));
                        chk("strobe_cycles", 32'(nstb), 32'(e.nstb));
                        if (ack) chk("rdata", 32'(odat), 32'(e.dat));
                    end
                    last_ack = cycle;
                end
            end
        end

        // drive a request at cycle 0 and queue what the word-level memory model predicts
        task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
            exp_t e;
            cyc = 1; stb = 1; we = w; adr = a; idat = d; sel = s;
            cur_adr = a; cur_we = w; cur_dat = d; cur_sel = s; nstb = 0;
            e.err = a >= 16'h8000;
            e.at = cycle + (e.err ? 1 : 2 * W + 3);
            e.nstb = e.err ? 0 : $countones(s) * (W + 1);
            e.dat = 16'h0000;
            if (!e.err) begin
                if (w) begin
                    if (s[0]) ref_mem[{a[8:0], 1'b0}] = d[7:0];
                    if (s[1]) ref_mem[{a[8:0], 1'b1}] = d[15:8];
                end else
                    e.dat = {s[1] ? ref_mem[{a[8:0], 1'b1}] : 8'h00, s[0] ? ref_mem[{a[8:0], 1'b0}] : 8'h00};
            end
            q.push_back(e);
        endtask

        task automatic wait_resp();
            bit seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                seen = ack | err;
            end
            if (!seen) chk("resp_timeout", 0, 1);
            @(posedge clk); #1;
        endtask

        task automatic idle();
            cyc = 0; stb = 0; we = 0;
        endtask

        task automatic xfer(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s, input bit drop_stb);
            issue(w, a, d, s);
            if (drop_stb) begin
                @(posedge clk); #1;
                stb = 0;
            end
            wait_resp();
        endtask

        initial begin
            int t0, bad;
            for (int i = 0; i < 1024; i++) begin
                mem[i] = 8'($urandom);
                ref_mem[i] = mem[i];
            end
            @(negedge clk);
            chk("rst_odat", 32'(odat), 0);
            chk("rst_ctrl", 32'({ack, err, oe, ewe, edo}), 0);
            chk("rst_ext_adr", 32'(eadr), 0);
            @(posedge clk); #1;
            rst_n = 1;
            @(posedge clk); #1;
            mem[10'h024] = 8'hCD; ref_mem[10'h024] = 8'hCD;
            mem[10'h025] = 8'hAB; ref_mem[10'h025] = 8'hAB;
            xfer(0, 16'h0012, 16'h0, 2'b11, 0); idle();
            xfer(1, 16'h0100, 16'h1234, 2'b01, 0); idle();
            xfer(0, 16'h8000, 16'h0, 2'b11, 0); idle();
            xfer(0, 16'h0100, 16'h0, 2'b11, 0); idle();
            for (int k = 0; k < 16; k++) begin
                mem[10'h080 + k] = 8'(k);
                ref_mem[10'h080 + k] = 8'(k);
            end
            t0 = cycle;
            for (int k = 0; k < 8; k++) xfer(0, 16'h0040 + 16'(k), 16'h0, 2'b11, 0);
            idle();
            chk("burst_span", 32'(last_ack - t0), 32'(8 * (2 * W + 4) - 1));
            for (int n = 0; n < 150; n++) begin
                logic [15:0] a;
                a = ($urandom_range(0, 7) == 0) ? (16'h8000 | 16'($urandom)) : 16'($urandom_range(0, 255));
                xfer(1'($urandom), a, 16'($urandom), 2'($urandom), $urandom_range(0, 4) == 0);
                if ($urandom_range(0, 2) == 0) begin
                    idle();
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            idle();
            @(posedge clk); #1;
            t0 = cycle;
            issue(0, 16'h0010, 16'h0, 2'b11);
            void'(q.pop_back());
            repeat (2) @(posedge clk);
            #1;
            idle();
            repeat (8) begin
                @(negedge clk);
                if (cycle >= t0 + 3) chk("abort_quiet", 32'({oe, ewe, ack, err}), 0);
            end
            @(posedge clk); #1;
            xfer(0, 16'h0011, 16'h0, 2'b11, 0); idle();
            t0 = cycle;
            issue(0, 16'h0012, 16'h0, 2'b11);
            do @(negedge clk); while (cycle < t0 + W + 2);
            chk("hi_oe_before_rst", 32'({oe, eadr}), 32'({1'b1, 17'h00025}));
            #1 rst_n = 0;
            #1;
            chk("async_rst_odat", 32'(odat), 0);
            chk("async_rst_ctrl", 32'({ack, err, oe, ewe, edo}), 0);
            chk("async_rst_ext_adr", 32'(eadr), 0);
            q.delete();
            @(posedge clk); #1;
            idle();
            rst_n = 1;
            @(posedge clk); #1;
            xfer(0, 16'h0012, 16'h0, 2'b11, 0); idle();
            repeat (3) @(posedge clk);
            bad = 0;
            for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_image_mismatches", 32'(bad), 0);
            chk("queue_drained", 32'(q.size()), 0);
            done[g] = 1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done[0] && done[1] && done[2]); i++) @(posedge clk);
        if (!(done[0] && done[1] && done[2])) chk("global_timeout", 32'({done[2], done[1], done[0]}), 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_extmem_responder.md
# wb_extmem_responder

Wishbone classic responder that bridges the 16-bit instruction/data bus onto an external 8-bit asynchronous memory. Each Wishbone word access is split into two byte phases, low byte then high byte, each with a configurable number of wait states. It sits at the far end of the bus driven by the fetch-side cache, which issues 8-beat line fetches by holding `wb_cyc`/`wb_stb` high and stepping `wb_adr` after each ack. It also serves single writes from the data side.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles per byte phase (0..15); a phase lasts WAIT_CYCLES+1 cycles.
- `ADDR_LIMIT`, default 16'h8000: word addresses >= this value terminate with `wb_err`.
- `i_clk` in 1: sole clock; all state changes on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `wb_cyc` in 1: bus cycle.
- `wb_stb` in 1: strobe.
- `wb_we` in 1: 1 = write.
- `wb_adr` in 16: word address.
- `wb_i_dat` in 16: write data.
- `wb_sel` in 2: byte lanes; bit0 = [7:0], bit1 = [15:8].
- `wb_o_dat` out 16: read data, valid while `wb_ack`=1.
- `wb_ack` out 1: one-cycle completion pulse.
- `wb_err` out 1: one-cycle error pulse.
- `ext_adr` out 17: byte address, {word addr, lane}.
- `ext_dat_o` out 8: write byte.
- `ext_dat_i` in 8: read byte.
- `ext_oe` out 1: read enable.
- `ext_we` out 1: write enable.

## Operation
- States: IDLE, LO, HI, ACK, ERR.
- Reset (`i_rst_n`=0): state IDLE, wait counter 0, all outputs 0, latched request cleared. Outputs clear immediately, not at the next edge.
- IDLE, `wb_cyc & wb_stb` sampled high:
  - If `wb_adr >= ADDR_LIMIT`: go to ERR. No external access.
  - Otherwise: latch adr, we, sel and wb_i_dat; load counter = WAIT_CYCLES; go to LO.
- LO:
  - `ext_adr = {adr,1'b0}` and `ext_dat_o = data[7:0]`.
  - If sel[0]=1: `ext_oe = ~we`, `ext_we = we`. If sel[0]=0: both stay 0.
  - Counter decrements each cycle. In the cycle where counter==0, a read with sel[0]=1 captures `ext_dat_i` into `wb_o_dat[7:0]`; a disabled lane captures 8'h00. Then reload counter and go to HI.
- HI: same as LO using `{adr,1'b1}`, data[15:8], sel[1] and `wb_o_dat[15:8]`. At counter==0 go to ACK.
- ACK: `wb_ack`=1 for exactly this cycle; go to IDLE. For writes `wb_o_dat` holds 16'h0000.
- ERR: `wb_err`=1 for exactly this cycle; go to IDLE.
- `ext_oe`/`ext_we` are 0 in IDLE, ACK and ERR. They are never both 1.
- Abort: if `wb_cyc`=0 is sampled in LO or HI, go to IDLE at the next edge, deassert the ext strobes, and issue no ack or err. If `wb_stb` drops while `wb_cyc` stays high, it is ignored until completion.
- `wb_ack` and `wb_err` are never asserted together, and never while `wb_cyc`=0 at the preceding edge.

## Timing
- Cycle 0 is the first cycle `wb_cyc & wb_stb` is high in IDLE.
- Normal access: LO occupies cycles 1..W+1, HI occupies cycles W+2..2W+2, `wb_ack` is high in cycle 2W+3 (W = WAIT_CYCLES).
- Error access: `wb_err` is high in cycle 1.
- Back to back: the next request is sampled in the cycle after ack, so one word takes 2W+4 cycles.
- 8-beat burst at W=0: 32 cycles from first stb to last ack.
- Read data: the byte on `ext_dat_i` must be stable in the last cycle of its phase. It is registered at that edge; there is no combinational path from `ext_dat_i` to `wb_o_dat`.
- All outputs are registered.

## Test plan
- Read, W=0, adr 16'h0012, ext memory bytes 0x24=8'hCD and 0x25=8'hAB: `ext_oe` high in cycles 1 and 2 with `ext_adr` 17'h00024 then 17'h00025; `wb_ack` high in cycle 3 with `wb_o_dat`=16'hABCD.
- Write, W=1, adr 16'h0100, data 16'h1234, sel 2'b01: `ext_we` high in cycles 1-2 at 17'h00200 with `ext_dat_o`=8'h34; strobes stay low in cycles 3-4; `wb_ack` high in cycle 5; byte 0x201 is unchanged.
- Address adr 16'h8000 with ADDR_LIMIT default: `wb_err` high in cycle 1; `ext_oe`/`ext_we` never assert; `wb_ack` stays 0.
- 8-beat burst, W=0, adr 16'h0040..16'h0047, memory filled with an incrementing pattern: 8 acks spaced 4 cycles apart, data matches the pattern, last ack at cycle 31.
- Drop `wb_cyc` in cycle 2 of a W=2 read: state returns to IDLE; `ext_oe`=0 from cycle 3; no ack or err; a following request completes normally.
- Assert `i_rst_n`=0 asynchronously mid-HI: all outputs go to 0 before the next edge; after release the first request behaves as in scenario 1.
